// File: rtl/bitmask_encoder_stream.sv
// ============================================================================
// Module  : bitmask_encoder_stream
// Brief   : Streams the binary index of every set bit of a WIDTH-bit vector,
//           one index per valid/ready beat. Define ENC_MSB_FIRST_EN for
//           descending (MSB-first) emission order; default is LSB-first.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module bitmask_encoder_stream #(
    parameter int WIDTH = 8,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_vec_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [IDX_W-1:0] out_idx_o,
    output logic             out_last_o,
    output logic             out_none_o
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   resid_q, resid_d;
    logic               none_q,  none_d;

    logic [IDX_W-1:0]   sel_idx;
    logic [WIDTH-1:0]   sel_mask;
    logic               at_most_one;
    logic               emit;
    logic               xfer;
    logic               accept;

    // Priority select: the last hit in loop order wins.
    always_comb begin
        sel_idx = '0;
`ifdef ENC_MSB_FIRST_EN
        for (int i = 0; i < WIDTH; i++) begin
            if (resid_q[i]) sel_idx = IDX_W'(i);
        end
`else
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (resid_q[i]) sel_idx = IDX_W'(i);
        end
`endif
    end

    assign sel_mask    = WIDTH'(1) << sel_idx;
    assign at_most_one = ((resid_q & (resid_q - WIDTH'(1))) == '0);

    assign emit        = (state_q == EMIT);
    assign out_valid_o = emit;
    assign out_idx_o   = emit ? sel_idx : '0;
    assign out_last_o  = emit & at_most_one;
    assign out_none_o  = emit & none_q;

    assign xfer        = emit & out_ready_i;
    // Combinational from out_ready so a new vector can follow the last beat.
    assign in_ready_o  = ~emit | (xfer & at_most_one);
    assign accept      = in_valid_i & in_ready_o;

    always_comb begin
        state_d = state_q;
        resid_d = resid_q;
        none_d  = none_q;
        if (accept) begin
            state_d = EMIT;
            resid_d = in_vec_i;
            none_d  = (in_vec_i == '0);
        end else if (xfer) begin
            resid_d = resid_q & ~sel_mask;
            if (at_most_one) begin
                state_d = IDLE;
                none_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            resid_q <= '0;
            none_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            resid_q <= resid_d;
            none_q  <= none_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bitmask_encoder_stream.sv
// ============================================================================
// Module  : tb_bitmask_encoder_stream
// Brief   : Scoreboard bench for bitmask_encoder_stream (both priority orders).
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bitmask_encoder_stream;

    localparam int WIDTH = 8;
    localparam int IDX_W = 3;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_vec;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_idx;
    logic             out_last;
    logic             out_none;

    bitmask_encoder_stream #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_vec_i    (in_vec),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_idx_o   (out_idx),
        .out_last_o  (out_last),
        .out_none_o  (out_none)
    );

    typedef struct {
        int idx;
        bit last;
        bit none;
    } beat_t;

    beat_t exp_q[$];
    int    xfer_cyc_q[$];
    int    n_vec  = 0;
    int    n_miss = 0;
    int    cyc    = 0;
    int    acc_cyc = 0;
    bit    rnd_bp = 0;

    bit               stall_q = 0;
    logic [IDX_W-1:0] st_idx;
    logic             st_last;
    logic             st_none;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        if (rnd_bp) begin
            #1 out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    // Reference model: expected beat list for one accepted vector.
    function automatic void push_exp(input logic [WIDTH-1:0] v);
        beat_t b;
        int    left;
        int    bit_i;
        if (v == '0) begin
            b.idx = 0; b.last = 1'b1; b.none = 1'b1;
            exp_q.push_back(b);
            return;
        end
        left = $countones(v);
        for (int k = 0; k < WIDTH; k++) begin
`ifdef ENC_MSB_FIRST_EN
            bit_i = WIDTH - 1 - k;
`else
            bit_i = k;
`endif
            if (v[bit_i]) begin
                left--;
                b.idx = bit_i; b.last = (left == 0); b.none = 1'b0;
                exp_q.push_back(b);
            end
        end
    endfunction

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        beat_t e;
        if (!rst_n) begin
            stall_q = 0;
        end else begin
            if (stall_q) begin
                check_val("hold_valid", out_valid, 1);
                check_val("hold_idx",   out_idx,   st_idx);
                check_val("hold_last",  out_last,  st_last);
                check_val("hold_none",  out_none,  st_none);
            end
            if (out_valid) begin
                if (out_ready) begin
                    check_val("in_ready_xfer", in_ready, out_last);
                    if (exp_q.size() == 0) begin
                        check_val("stray_beat", out_idx, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check_val("beat_idx",  out_idx,  e.idx);
                        check_val("beat_last", out_last, e.last);
                        check_val("beat_none", out_none, e.none);
                    end
                    xfer_cyc_q.push_back(cyc);
                    stall_q = 0;
                end else begin
                    check_val("in_ready_stall", in_ready, 0);
                    stall_q = 1;
                    st_idx  = out_idx;
                    st_last = out_last;
                    st_none = out_none;
                end
            end else begin
                stall_q = 0;
                check_val("idle_idx",   out_idx,  0);
                check_val("idle_last",  out_last, 0);
                check_val("idle_none",  out_none, 0);
                check_val("idle_ready", in_ready, 1);
            end
        end
    end

    // Called in the posedge+1 phase; returns in the posedge+1 phase after acceptance.
    task automatic send(input logic [WIDTH-1:0] v);
        int t = 0;
        in_valid = 1'b1;
        in_vec   = v;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            check_val("accept_timeout", 1, 0);
        end else begin
            push_exp(v);
            acc_cyc = cyc;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_vec   = WIDTH'($urandom);
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 300) check_val("drain_timeout", exp_q.size(), 0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_vec    = '0;
        out_ready = 1'b1;

        // Reset and idle
        #1;
        check_val("rst_valid", out_valid, 0);
        check_val("rst_ready", in_ready,  1);
        check_val("rst_idx",   out_idx,   0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end

        // Single vector: order, latency, one beat per cycle
        xfer_cyc_q.delete();
        send(8'b1010_0110);
        drain();
        check_val("single_beats",   xfer_cyc_q.size(), 4);
        check_val("single_latency", xfer_cyc_q[0] - acc_cyc, 1);
        check_val("single_span",    xfer_cyc_q[3] - xfer_cyc_q[0], 3);

        // Zero and full vectors
        send(8'h00);
        drain();
        xfer_cyc_q.delete();
        send(8'hFF);
        drain();
        check_val("full_beats", xfer_cyc_q.size(), 8);

        // Backpressure
        out_ready = 1'b0;
        send(8'b0001_0001);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        check_val("bp_valid", out_valid, 1);
        check_val("bp_last",  out_last,  0);
        check_val("bp_ready", in_ready,  0);
        out_ready = 1'b1;
        drain();

        // Back-to-back vectors without a bubble
        xfer_cyc_q.delete();
        send(8'h01);
        send(8'h80);
        drain();
        check_val("b2b_beats", xfer_cyc_q.size(), 2);
        check_val("b2b_gap",   xfer_cyc_q[1] - xfer_cyc_q[0], 1);

        // Randomized vectors under random backpressure
        rnd_bp = 1;
        for (int i = 0; i < 24; i++) send(WIDTH'($urandom));
        rnd_bp = 0;
        @(posedge clk);
        #2 out_ready = 1'b1;
        drain();

        // Asynchronous reset mid-vector
        send(8'hF0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check_val("mid_rst_valid", out_valid, 0);
        check_val("mid_rst_ready", in_ready,  1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        send(8'h08);
        drain();

        check_val("sb_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/bitmask_encoder_stream.md
Name: bitmask_encoder_stream

Overview:
- Inverse of the team's 3-to-8 one-hot decoder: takes a WIDTH-bit bit vector and emits the binary index of every set bit, one index per output beat.
- Used wherever a decoded select/request mask must be turned back into indices, for example to replay a set of decoded lines in order.
- Input and output both use valid/ready handshakes. The block holds at most one vector in flight.

Parameters:
- WIDTH, 8, width of the input vector.
- IDX_W, 3, width of the output index; must equal clog2(WIDTH). The default pair 8/3 mirrors the 3-to-8 decoder.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_vec is valid.
- in_ready  output  1  block can accept a vector this cycle.
- in_vec  input  WIDTH  vector to encode.
- out_valid  output  1  out_idx, out_last and out_none are valid.
- out_ready  input  1  downstream consumes the beat this cycle.
- out_idx  output  IDX_W  binary index of the current set bit.
- out_last  output  1  current beat is the final beat for this vector.
- out_none  output  1  the accepted vector was all-zero; this beat carries no index.

Behaviour:
- State machine has two states: IDLE and EMIT.
  - Internal registers: state, resid[WIDTH-1:0] (bits not yet emitted), none_r.
- Reset (rst_n=0, asynchronous): state=IDLE, resid=0, none_r=0.
  - Outputs during reset: out_valid=0, out_idx=0, out_last=0, out_none=0, in_ready=1.
  - Reset asserted mid-vector discards the remaining bits. No partial beat is emitted after reset releases.
- Input acceptance: a vector is accepted on a clock edge where in_valid=1 and in_ready=1.
  - in_ready = (state==IDLE) | (out_valid & out_ready & out_last). This path is combinational from out_ready so back-to-back vectors need no bubble.
- On acceptance:
  - resid <= in_vec, none_r <= (in_vec==0), state <= EMIT.
  - First out_valid appears in the next cycle, so latency is 1 cycle.
- In EMIT:
  - out_valid=1.
  - out_idx = index of the lowest set bit of resid (LSB-first priority).
  - out_last=1 when resid has at most one bit set.
  - out_none = none_r. When none_r=1: exactly one beat, out_idx=0, out_last=1.
- Outputs depend only on registers, except in_ready as noted above.
- Beat transfer (out_valid & out_ready):
  - Clear the emitted bit in resid.
  - If out_last=1: go to IDLE, unless a new vector is accepted on the same edge, in which case load it and stay in EMIT.
- Stall: with out_ready=0, out_idx, out_last and out_none hold stable and resid is unchanged.
- in_vec is sampled only at acceptance. Changes to in_vec at other times have no effect.
- Beats per vector = popcount(in_vec), or 1 if in_vec==0.
  - With continuous out_ready, throughput is one beat per cycle.
  - A full vector (all ones) takes WIDTH beats.
- Index arithmetic is unsigned, 0..WIDTH-1, and never wraps.
- If out_valid=0 (IDLE): out_idx=0, out_last=0, out_none=0.

Optional Feature:
- Macro: ENC_MSB_FIRST_EN.
- Defined: priority order is reversed. out_idx is the highest set bit of resid, and beats are emitted in descending index order.
- Not defined: LSB-first as above.
- All handshake, latency, out_last and out_none rules are identical in both builds.

Test Plan:
- Reset then idle: rst_n low 3 cycles, then high, in_valid=0 -> out_valid=0, in_ready=1, out_idx=0 throughout.
- Single vector, LSB-first: in_vec=8'b1010_0110, out_ready=1 -> from the cycle after acceptance, beats idx 1, 2, 5, 7 in 4 consecutive cycles; out_last=1 only on idx 7; then IDLE.
  - With ENC_MSB_FIRST_EN: same vector -> beats 7, 5, 2, 1.
- Zero and full vectors: in_vec=8'h00 -> one beat with out_none=1, out_idx=0, out_last=1. in_vec=8'hFF -> 8 beats, idx 0..7, out_last=1 on idx 7.
- Backpressure: in_vec=8'b0001_0001, out_ready=0 for 4 cycles -> idx 0 held stable with out_last=0 and in_ready=0. Raise out_ready -> beats 0 then 4; in_ready=1 in the idx-4 transfer cycle.
- Back-to-back: in_valid held with 8'h01 then 8'h80 -> beats idx 0 (last) and idx 7 (last) in consecutive cycles, with no bubble between vectors.
- Reset mid-operation: in_vec=8'hF0, assert rst_n=0 asynchronously after beat idx 4 -> out_valid drops immediately. After release: IDLE, in_ready=1, no stray beats for idx 5..7.
